// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: stall vector layout, stop encoding, bubble defaults,
// per-stage payload widths and the per-edge update action of a stage register.
package cpu_pipe_pkg;

  localparam int unsigned STALL_W = 6;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Wide enough for any stage payload; instances slice the low DATA_W bits.
  localparam int unsigned  BUBBLE_MAX_W       = 1024;
  localparam logic [BUBBLE_MAX_W-1:0] DEFAULT_BUBBLE_VAL = '0;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 200;
  localparam int unsigned EX_MEM_W = 112;
  localparam int unsigned MEM_WB_W = 72;

  typedef enum logic [2:0] {
    UPD_RESET,
    UPD_FLUSH,
    UPD_HOLD,
    UPD_SKID,
    UPD_BUBBLE,
    UPD_LOAD
  } pipe_upd_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with sticky sideband, stall/flush, handshake
// and hold/bubble counters. Define PIPE_STAGE_SKID_EN for a 1-entry skid buffer.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 200,
  parameter int unsigned       STICKY_W   = 1,
  parameter int unsigned       STALL_W    = cpu_pipe_pkg::STALL_W,
  parameter int unsigned       STAGE      = cpu_pipe_pkg::STALL_EX,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = cpu_pipe_pkg::DEFAULT_BUBBLE_VAL[DATA_W-1:0],
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [STICKY_W-1:0] in_sticky,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [STICKY_W-1:0] out_sticky,
  output logic [CNT_W-1:0]    hold_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  cpu_pipe_pkg::pipe_upd_e upd;

  logic up_stall;
  logic dn_stall;
  logic hold;
  logic unused_stall;

  assign up_stall     = (stall[STAGE]   == cpu_pipe_pkg::STOP);
  assign dn_stall     = (stall[STAGE+1] == cpu_pipe_pkg::STOP);
  assign hold         = dn_stall || (out_valid && !out_ready);
  assign unused_stall = ^stall;

`ifdef PIPE_STAGE_SKID_EN
  logic                skid_valid;
  logic [DATA_W-1:0]   skid_data;
  logic [STICKY_W-1:0] skid_sticky;

  assign in_ready = !skid_valid;
`else
  assign in_ready = !rst && !flush && !hold && !up_stall;
`endif

  always_comb begin
    upd = cpu_pipe_pkg::UPD_LOAD;
    if (rst) begin
      upd = cpu_pipe_pkg::UPD_RESET;
    end else if (flush) begin
      upd = cpu_pipe_pkg::UPD_FLUSH;
    end else if (hold) begin
      upd = cpu_pipe_pkg::UPD_HOLD;
`ifdef PIPE_STAGE_SKID_EN
    end else if (skid_valid) begin
      upd = cpu_pipe_pkg::UPD_SKID;
`endif
    end else if (up_stall || !in_valid) begin
      upd = cpu_pipe_pkg::UPD_BUBBLE;
    end
  end

  // Sticky sideband is left untouched on bubbles; only reset/flush clear it.
  always_ff @(posedge clk) begin
    case (upd)
      cpu_pipe_pkg::UPD_RESET,
      cpu_pipe_pkg::UPD_FLUSH: begin
        out_valid  <= 1'b0;
        out_data   <= BUBBLE_VAL;
        out_sticky <= '0;
      end
      cpu_pipe_pkg::UPD_BUBBLE: begin
        out_valid <= 1'b0;
        out_data  <= BUBBLE_VAL;
      end
      cpu_pipe_pkg::UPD_LOAD: begin
        out_valid  <= 1'b1;
        out_data   <= in_data;
        out_sticky <= in_sticky;
      end
`ifdef PIPE_STAGE_SKID_EN
      cpu_pipe_pkg::UPD_SKID: begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_sticky <= skid_sticky;
      end
`endif
      default: ;
    endcase
  end

`ifdef PIPE_STAGE_SKID_EN
  // A payload accepted while the stage holds is parked until the next free edge.
  always_ff @(posedge clk) begin
    if (upd == cpu_pipe_pkg::UPD_RESET || upd == cpu_pipe_pkg::UPD_FLUSH) begin
      skid_valid <= 1'b0;
    end else if (upd == cpu_pipe_pkg::UPD_HOLD && in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end else if (upd == cpu_pipe_pkg::UPD_SKID) begin
      skid_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (upd == cpu_pipe_pkg::UPD_HOLD && in_valid && !skid_valid) begin
      skid_data   <= in_data;
      skid_sticky <= in_sticky;
    end
  end
`endif

  pipe_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (upd == cpu_pipe_pkg::UPD_HOLD),
    .cnt (hold_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((upd == cpu_pipe_pkg::UPD_BUBBLE) && up_stall),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vectors, a rule-level model
// checked every cycle, and literal expectations at key points.
module tb_pipe_stage_reg;
  import cpu_pipe_pkg::*;

  localparam int unsigned DW   = 16;
  localparam logic [DW-1:0] BUB = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [0:0]    in_sticky;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [0:0]    out_sticky;
  logic [15:0]   hold_cnt;
  logic [15:0]   bubble_cnt;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [0:0]    s_out_sticky;
  logic [1:0]    s_hold_cnt, s_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DW), .STICKY_W(1), .STALL_W(6), .STAGE(3), .BUBBLE_VAL(BUB), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .STICKY_W(1), .STALL_W(6), .STAGE(3), .BUBBLE_VAL(BUB), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_sticky(in_sticky),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_sticky(s_out_sticky), .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain rule evaluation with unbounded integer counters saturated at compare time.
  bit          m_v = 1'b0;
  logic [DW-1:0] m_d = BUB;
  logic        m_s = 1'b0;
  int          m_hold = 0;
  int          m_bub  = 0;
  bit          k_v = 1'b0;
  logic [DW-1:0] k_d = '0;
  logic        k_s = 1'b0;

  function automatic bit m_is_hold();
    return (stall[4] == STOP) || (m_v && !out_ready);
  endfunction

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return !k_v;
`else
    return !rst && !flush && !m_is_hold() && (stall[3] != STOP);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_v = 1'b0; m_d = BUB; m_s = 1'b0; m_hold = 0; m_bub = 0; k_v = 1'b0;
    end else if (flush) begin
      m_v = 1'b0; m_d = BUB; m_s = 1'b0; k_v = 1'b0;
    end else if (m_is_hold()) begin
      m_hold++;
`ifdef PIPE_STAGE_SKID_EN
      if (in_valid && !k_v) begin
        k_v = 1'b1; k_d = in_data; k_s = in_sticky[0];
      end
    end else if (k_v) begin
      m_v = 1'b1; m_d = k_d; m_s = k_s; k_v = 1'b0;
`endif
    end else if ((stall[3] == STOP) || !in_valid) begin
      m_v = 1'b0; m_d = BUB;
      if (stall[3] == STOP) m_bub++;
    end else begin
      m_v = 1'b1; m_d = in_data; m_s = in_sticky[0];
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model out_valid", 32'(out_valid), 32'(m_v));
      chk("model out_data", 32'(out_data), 32'(m_d));
      chk("model out_sticky", 32'(out_sticky), 32'(m_s));
      chk("model hold_cnt", 32'(hold_cnt), (m_hold > 65535) ? 32'd65535 : 32'(m_hold));
      chk("model bubble_cnt", 32'(bubble_cnt), (m_bub > 65535) ? 32'd65535 : 32'(m_bub));
      chk("model in_ready", 32'(in_ready), 32'(m_in_ready()));
      chk("model sat hold_cnt", 32'(s_hold_cnt), (m_hold > 3) ? 32'd3 : 32'(m_hold));
    end
  end

  task automatic drive(input logic r, input logic [5:0] st, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic s, input logic ordy);
    rst = r; stall = st; flush = fl; in_valid = iv; in_data = d; in_sticky = s;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [5:0]    st;
    logic          iv;
    logic [DW-1:0] d;
    logic          s;
    logic          ordy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs = '{
      '{6'b000000, 1'b1, 16'h00A1, 1'b1, 1'b1},
      '{6'b000000, 1'b1, 16'h00A2, 1'b0, 1'b0},
      '{6'b000000, 1'b1, 16'h00A3, 1'b1, 1'b1},
      '{6'b010000, 1'b1, 16'h00A4, 1'b0, 1'b1},
      '{6'b001000, 1'b1, 16'h00A5, 1'b0, 1'b1},
      '{6'b000000, 1'b0, 16'h00A6, 1'b1, 1'b1},
      '{6'b000100, 1'b1, 16'h00A7, 1'b1, 1'b1},
      '{6'b100000, 1'b1, 16'h00A8, 1'b0, 1'b1},
      '{6'b011000, 1'b1, 16'h00A9, 1'b1, 1'b0},
      '{6'b000000, 1'b1, 16'h00AA, 1'b1, 1'b0},
      '{6'b000000, 1'b1, 16'h00AB, 1'b0, 1'b1},
      '{6'b001000, 1'b0, 16'h00AC, 1'b1, 1'b0}
    };

    // Reset with a live-looking input must still give the bubble state.
    drive(1'b1, 6'b000000, 1'b0, 1'b1, 16'h0ABC, 1'b1, 1'b1);
    tick();
    armed = 1'b1;
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'hDEAD);
    chk("reset out_sticky", 32'(out_sticky), 32'd0);
    chk("reset hold_cnt", 32'(hold_cnt), 32'd0);
    chk("reset bubble_cnt", 32'(bubble_cnt), 32'd0);

    // Streaming 1,2,3.
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
    #1 chk("stream in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("stream d1", 32'(out_data), 32'h0001);
    chk("stream v1", 32'(out_valid), 32'd1);
    in_data = 16'h0002; tick();
    chk("stream d2", 32'(out_data), 32'h0002);
    in_data = 16'h0003; tick();
    chk("stream d3", 32'(out_data), 32'h0003);
    chk("stream sticky", 32'(out_sticky), 32'd1);

    // Upstream stall bubble: sticky survives.
    drive(1'b0, 6'b001000, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1);
`ifndef PIPE_STAGE_SKID_EN
    #1 chk("bubble in_ready", 32'(in_ready), 32'd0);
`endif
    tick();
    chk("bubble out_valid", 32'(out_valid), 32'd0);
    chk("bubble out_data", 32'(out_data), 32'hDEAD);
    chk("bubble out_sticky", 32'(out_sticky), 32'd1);
    chk("bubble bubble_cnt", 32'(bubble_cnt), 32'd1);

    // Hold 0x55 by downstream stall, then by out_ready=0.
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 16'h0055, 1'b1, 1'b1);
    tick();
    chk("load 55", 32'(out_data), 32'h0055);
    drive(1'b0, 6'b011000, 1'b0, 1'b0, 16'h0066, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold stall data", 32'(out_data), 32'h0055);
      chk("hold stall valid", 32'(out_valid), 32'd1);
    end
    chk("hold stall cnt", 32'(hold_cnt), 32'd3);
    drive(1'b0, 6'b000000, 1'b0, 1'b0, 16'h0066, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold ordy data", 32'(out_data), 32'h0055);
      chk("hold ordy valid", 32'(out_valid), 32'd1);
    end
    chk("hold ordy cnt", 32'(hold_cnt), 32'd6);
    chk("sat hold_cnt", 32'(s_hold_cnt), 32'd3);

    // Flush during hold.
    drive(1'b0, 6'b011000, 1'b1, 1'b1, 16'h0077, 1'b1, 1'b0);
    tick();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush out_sticky", 32'(out_sticky), 32'd0);
    chk("flush out_data", 32'(out_data), 32'hDEAD);
    chk("flush hold_cnt", 32'(hold_cnt), 32'd6);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vecs[i].st, 1'b0, vecs[i].iv, vecs[i].d, vecs[i].s, vecs[i].ordy);
      tick();
    end

    // Reset while holding discards the payload.
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 16'h0088, 1'b1, 1'b1);
    tick();
    drive(1'b0, 6'b010000, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst hold out_valid", 32'(out_valid), 32'd0);
    chk("rst hold out_data", 32'(out_data), 32'hDEAD);
    chk("rst hold hold_cnt", 32'(hold_cnt), 32'd0);

`ifdef PIPE_STAGE_SKID_EN
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
    tick();
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b0);
    #1 chk("skid in_ready before", 32'(in_ready), 32'd1);
    tick();
    chk("skid in_ready full", 32'(in_ready), 32'd0);
    chk("skid out_data held", 32'(out_data), 32'h0010);
    drive(1'b0, 6'b000000, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b1);
    tick();
    chk("skid out_data", 32'(out_data), 32'h0011);
    chk("skid out_valid", 32'(out_valid), 32'd1);
    chk("skid in_ready empty", 32'(in_ready), 32'd1);
`endif

    drive(1'b0, 6'b000000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
